// File: rtl/snax_cgra_ctrl_pkg.sv
// Shared types and constants for the SNAX CGRA launch sequencer.
package snax_cgra_ctrl_pkg;

    // Sequencer states; the encoding is exported on status bits [5:3].
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Status word bit positions.
    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_DONE      = 1;
    localparam int unsigned STATUS_ERR       = 2;
    localparam int unsigned STATUS_STATE_LSB = 3;

    // Read-only CSR word indices.
    localparam int unsigned CSR_STATUS    = 0;
    localparam int unsigned CSR_CYCLES    = 1;
    localparam int unsigned CSR_OUT_BEATS = 2;
    localparam int unsigned CSR_IN_BEATS  = 3;

    // Population count of up to 32 strobes (narrower vectors are zero-extended).
    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            cnt = cnt + {5'b0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/snax_cgra_beat_counter.sv
// Saturating beat accumulator: adds the number of set strobes each enabled cycle.
module snax_cgra_beat_counter
    import snax_cgra_ctrl_pkg::*;
#(
    parameter int unsigned NumStreams = 8,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [NumStreams-1:0] strobe_i,
    output logic [CntWidth-1:0]   count_o
);

    logic [CntWidth-1:0] count_q;
    logic [CntWidth-1:0] count_d;
    logic [CntWidth:0]   sum;

    // Next count: accumulate strobes, clamp at all-ones on carry out.
    always_comb begin
        sum     = {1'b0, count_q} + (CntWidth + 1)'(popcount(32'(strobe_i)));
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = sum[CntWidth] ? '1 : sum[CntWidth-1:0];
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/snax_cgra_launch_ctrl.sv
// Launch sequencer: forwards a command to the CGRA CSR port, then counts
// streamer beats until the expected number of output beats is produced.
module snax_cgra_launch_ctrl
    import snax_cgra_ctrl_pkg::*;
#(
    parameter int unsigned NumStreams = 8,
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned AckTimeout = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0][31:0]      csr_set_i,
    input  logic                  csr_set_valid_i,
    output logic                  csr_set_ready_o,
    output logic [31:0]           cgra_csr_o,
    output logic                  cgra_csr_valid_o,
    input  logic                  cgra_csr_ack_i,
    input  logic [NumStreams-1:0] out_fire_i,
    input  logic [NumStreams-1:0] in_fire_i,
    output logic [3:0][31:0]      csr_ro_o,
    output logic                  done_o
);

    localparam logic [31:0] TimeoutLast = (AckTimeout == 0) ? 32'd0 : 32'(AckTimeout - 1);

    state_e              state_q;
    logic [31:0]         cmd_q;
    logic [31:0]         exp_q;
    logic                valid_q;
    logic                done_pulse_q;
    logic                done_q;
    logic                err_q;
    logic [31:0]         to_cnt_q;
    logic [CntWidth-1:0] cycles_q;

    logic                accept;
    logic                in_run;
    logic                reached;
    logic [CntWidth-1:0] out_beats;
    logic [CntWidth-1:0] in_beats;
    logic [31:0]         status;

    assign csr_set_ready_o = !rst_i && (state_q == ST_IDLE || state_q == ST_ERR);
    assign accept          = csr_set_valid_i && csr_set_ready_o;
    assign in_run          = (state_q == ST_RUN);

    // Crossing test uses the unsaturated sum so overshoot in one cycle still ends the run.
    assign reached = (33'(out_beats) + 33'(popcount(32'(out_fire_i)))) >= 33'(exp_q);

    snax_cgra_beat_counter #(
        .NumStreams (NumStreams),
        .CntWidth   (CntWidth)
    ) i_out_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept),
        .en_i     (in_run),
        .strobe_i (out_fire_i),
        .count_o  (out_beats)
    );

    snax_cgra_beat_counter #(
        .NumStreams (NumStreams),
        .CntWidth   (CntWidth)
    ) i_in_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept),
        .en_i     (in_run),
        .strobe_i (in_fire_i),
        .count_o  (in_beats)
    );

    // Sequencer FSM with registered handshake, pulse, sticky flags and cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            exp_q        <= '0;
            valid_q      <= 1'b0;
            done_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            to_cnt_q     <= '0;
            cycles_q     <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (accept) begin
                        cmd_q    <= csr_set_i[0];
                        exp_q    <= csr_set_i[1];
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        to_cnt_q <= '0;
                        cycles_q <= '0;
                        valid_q  <= 1'b1;
                        state_q  <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + CntWidth'(1);
                    if (cgra_csr_ack_i) begin
                        valid_q <= 1'b0;
                        if (exp_q == '0) begin
                            done_pulse_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else if (AckTimeout != 0 && to_cnt_q == TimeoutLast) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                ST_RUN: begin
                    if (cycles_q != '1) cycles_q <= cycles_q + CntWidth'(1);
                    if (reached) begin
                        done_pulse_q <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and read-only CSR assembly from registered state.
    always_comb begin
        status                                       = '0;
        status[STATUS_BUSY]                          = (state_q == ST_CFG) || (state_q == ST_RUN);
        status[STATUS_DONE]                          = done_q;
        status[STATUS_ERR]                           = err_q;
        status[STATUS_STATE_LSB +: 3]                = state_q;
        csr_ro_o                                     = '0;
        csr_ro_o[CSR_STATUS]                         = status;
        csr_ro_o[CSR_CYCLES]                         = 32'(cycles_q);
        csr_ro_o[CSR_OUT_BEATS]                      = 32'(out_beats);
        csr_ro_o[CSR_IN_BEATS]                       = 32'(in_beats);
    end

    assign cgra_csr_o       = cmd_q;
    assign cgra_csr_valid_o = valid_q;
    assign done_o           = done_pulse_q;

endmodule

// File: tb/tb_snax_cgra_launch_ctrl.sv
// Directed self-checking bench for snax_cgra_launch_ctrl.
module tb_snax_cgra_launch_ctrl;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [1:0][31:0] csr_set_i;
    logic            csr_set_valid_i;
    logic            csr_set_ready_o;
    logic [31:0]     cgra_csr_o;
    logic            cgra_csr_valid_o;
    logic            cgra_csr_ack_i;
    logic [7:0]      out_fire_i;
    logic [7:0]      in_fire_i;
    logic [3:0][31:0] csr_ro_o;
    logic            done_o;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned valid_cycles = 0;
    int unsigned done_pulses  = 0;
    int unsigned vbase;
    int unsigned dbase;

    snax_cgra_launch_ctrl #(
        .NumStreams (8),
        .CntWidth   (32),
        .AckTimeout (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .csr_set_i        (csr_set_i),
        .csr_set_valid_i  (csr_set_valid_i),
        .csr_set_ready_o  (csr_set_ready_o),
        .cgra_csr_o       (cgra_csr_o),
        .cgra_csr_valid_o (cgra_csr_valid_o),
        .cgra_csr_ack_i   (cgra_csr_ack_i),
        .out_fire_i       (out_fire_i),
        .in_fire_i        (in_fire_i),
        .csr_ro_o         (csr_ro_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed activity counters, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (cgra_csr_valid_o) valid_cycles++;
        if (done_o) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request in the current cycle, advance to the first CFG cycle.
    task automatic launch(input logic [31:0] cmd, input logic [31:0] expct);
        csr_set_i[0]    = cmd;
        csr_set_i[1]    = expct;
        csr_set_valid_i = 1'b1;
        check("ready_at_accept", 32'(csr_set_ready_o), 32'd1);
        step();
        csr_set_valid_i = 1'b0;
        check("valid_first_cfg", 32'(cgra_csr_valid_o), 32'd1);
        check("cmd_in_cfg", cgra_csr_o, cmd);
    endtask

    initial begin
        rst_i = 1'b1; csr_set_i = '0; csr_set_valid_i = 1'b0;
        cgra_csr_ack_i = 1'b0; out_fire_i = '0; in_fire_i = '0;
        #1;
        step(); step();
        check("ready_in_reset", 32'(csr_set_ready_o), 32'd0);
        rst_i = 1'b0;
        step();
        check("rst_ready", 32'(csr_set_ready_o), 32'd1);
        check("rst_status", csr_ro_o[0], 32'h0);
        check("rst_cycles", csr_ro_o[1], 32'h0);
        check("rst_out", csr_ro_o[2], 32'h0);
        check("rst_in", csr_ro_o[3], 32'h0);
        check("rst_cmd", cgra_csr_o, 32'h0);
        check("rst_valid", 32'(cgra_csr_valid_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);

        // Basic run: ack in third valid cycle, 2 beats/cycle for 8 cycles.
        vbase = valid_cycles; dbase = done_pulses;
        launch(32'hA5A5_0001, 32'd16);
        check("t1_status_cfg", csr_ro_o[0], 32'h09);
        step();
        check("t1_valid2", 32'(cgra_csr_valid_o), 32'd1);
        step();
        check("t1_cmd_stable", cgra_csr_o, 32'hA5A5_0001);
        cgra_csr_ack_i = 1'b1;
        step();
        cgra_csr_ack_i = 1'b0;
        check("t1_valid_drop", 32'(cgra_csr_valid_o), 32'd0);
        check("t1_status_run", csr_ro_o[0], 32'h11);
        out_fire_i = 8'h03;
        for (int i = 0; i < 7; i++) step();
        check("t1_no_early_done", 32'(done_o), 32'd0);
        check("t1_out14", csr_ro_o[2], 32'd14);
        step();
        out_fire_i = '0;
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_out16", csr_ro_o[2], 32'd16);
        check("t1_status_done", csr_ro_o[0], 32'h1A);
        check("t1_cycles", csr_ro_o[1], 32'd11);
        step();
        check("t1_idle_status", csr_ro_o[0], 32'h02);
        check("t1_ready", 32'(csr_set_ready_o), 32'd1);
        check("t1_valid_cnt", valid_cycles - vbase, 32'd3);
        check("t1_done_cnt", done_pulses - dbase, 32'd1);
        check("t1_out_hold", csr_ro_o[2], 32'd16);

        // Overshoot: 4 beats then 8 beats against expected 10.
        launch(32'h0000_0002, 32'd10);
        check("t2_clear_out", csr_ro_o[2], 32'd0);
        check("t2_clear_status", csr_ro_o[0], 32'h09);
        cgra_csr_ack_i = 1'b1;
        step();
        cgra_csr_ack_i = 1'b0;
        out_fire_i = 8'h0F; in_fire_i = 8'h01;
        step();
        check("t2_out4", csr_ro_o[2], 32'd4);
        check("t2_not_done", 32'(done_o), 32'd0);
        out_fire_i = 8'hFF;
        step();
        out_fire_i = '0; in_fire_i = '0;
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_out12", csr_ro_o[2], 32'd12);
        check("t2_in2", csr_ro_o[3], 32'd2);
        check("t2_cycles", csr_ro_o[1], 32'd3);
        step();

        // Expected zero: CFG straight to DONE; fires during CFG are ignored.
        dbase = done_pulses;
        launch(32'h0000_0003, 32'd0);
        cgra_csr_ack_i = 1'b1; out_fire_i = 8'hFF;
        step();
        cgra_csr_ack_i = 1'b0; out_fire_i = '0;
        check("t3_status_done", csr_ro_o[0], 32'h1A);
        check("t3_done", 32'(done_o), 32'd1);
        check("t3_out0", csr_ro_o[2], 32'd0);
        check("t3_cycles", csr_ro_o[1], 32'd1);
        step();
        check("t3_done_cnt", done_pulses - dbase, 32'd1);

        // Timeout after 4 unacknowledged CFG cycles.
        vbase = valid_cycles;
        launch(32'h0000_0004, 32'd5);
        step(); step(); step();
        check("t4_valid_last", 32'(cgra_csr_valid_o), 32'd1);
        step();
        check("t4_status_err", csr_ro_o[0], 32'h24);
        check("t4_valid_low", 32'(cgra_csr_valid_o), 32'd0);
        check("t4_ready", 32'(csr_set_ready_o), 32'd1);
        check("t4_valid_cnt", valid_cycles - vbase, 32'd4);
        check("t4_cycles", csr_ro_o[1], 32'd4);

        // Relaunch from ERR; ack arrives in the last allowed cycle and wins.
        launch(32'h0000_0005, 32'd100);
        check("t4_err_cleared", csr_ro_o[0], 32'h09);
        check("t4_cycles_cleared", csr_ro_o[1], 32'd0);
        step(); step(); step();
        cgra_csr_ack_i = 1'b1;
        step();
        cgra_csr_ack_i = 1'b0;
        check("t4_late_ack_run", csr_ro_o[0], 32'h11);

        // Reset mid-RUN with counts 5/7.
        dbase = done_pulses;
        out_fire_i = 8'h1F; in_fire_i = 8'h7F;
        step();
        out_fire_i = '0; in_fire_i = '0;
        check("t5_out5", csr_ro_o[2], 32'd5);
        check("t5_in7", csr_ro_o[3], 32'd7);
        rst_i = 1'b1;
        step();
        check("t5_status0", csr_ro_o[0], 32'h0);
        check("t5_cycles0", csr_ro_o[1], 32'h0);
        check("t5_out0", csr_ro_o[2], 32'h0);
        check("t5_in0", csr_ro_o[3], 32'h0);
        check("t5_valid0", 32'(cgra_csr_valid_o), 32'd0);
        check("t5_ready_rst", 32'(csr_set_ready_o), 32'd0);
        rst_i = 1'b0;
        out_fire_i = 8'hFF; in_fire_i = 8'hFF;
        step(); step();
        out_fire_i = '0; in_fire_i = '0;
        check("t5_idle_out", csr_ro_o[2], 32'h0);
        check("t5_idle_in", csr_ro_o[3], 32'h0);
        check("t5_no_done", done_pulses - dbase, 32'd0);
        check("t5_ready", 32'(csr_set_ready_o), 32'd1);

        // Back-to-back with request valid held high.
        launch(32'h0000_0006, 32'd2);
        csr_set_valid_i = 1'b1;
        check("t6_ready_cfg", 32'(csr_set_ready_o), 32'd0);
        cgra_csr_ack_i = 1'b1;
        step();
        cgra_csr_ack_i = 1'b0;
        check("t6_ready_run", 32'(csr_set_ready_o), 32'd0);
        out_fire_i = 8'h03;
        step();
        out_fire_i = '0;
        csr_set_i[0] = 32'h0000_0007;
        check("t6_done", 32'(done_o), 32'd1);
        check("t6_ready_done", 32'(csr_set_ready_o), 32'd0);
        step();
        check("t6_ready_second", 32'(csr_set_ready_o), 32'd1);
        step();
        csr_set_valid_i = 1'b0;
        check("t6_second_cfg", csr_ro_o[0], 32'h09);
        check("t6_second_cmd", cgra_csr_o, 32'h0000_0007);
        check("t6_second_valid", 32'(cgra_csr_valid_o), 32'd1);
        cgra_csr_ack_i = 1'b1;
        step();
        cgra_csr_ack_i = 1'b0;
        out_fire_i = 8'h81;
        step();
        out_fire_i = '0;
        check("t6_second_done", 32'(done_o), 32'd1);
        check("t6_second_out", csr_ro_o[2], 32'd2);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/snax_cgra_launch_ctrl.md
# snax_cgra_launch_ctrl

Launch sequencer between the SNAX CSR manager and the CGRA shell wrapper. It accepts a two-word launch request and forwards the command word to the CGRA RW-CSR port with a valid/ack handshake, bounding the wait with a timeout. It then observes streamer fire strobes and declares the run complete once the expected number of output beats has been produced. Status, cycle count and beat counts are exported as four read-only CSRs.

## Interface
- NumStreams, 8, number of acc2stream / stream2acc channels observed
- CntWidth, 32, width of cycle and beat counters (≤32)
- AckTimeout, 1024, max CFG cycles waiting for ack; 0 disables the timeout
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- csr_set_i  in  2x32  [0] CGRA command word, [1] expected output beats
- csr_set_valid_i  in  1  launch request valid
- csr_set_ready_o  out  1  launch request accepted when valid&ready
- cgra_csr_o  out  32  command word to CGRA cgra_csr_rw[0]
- cgra_csr_valid_o  out  1  to cgra_csr_rw_valid
- cgra_csr_ack_i  in  1  from cgra_csr_rw_ack
- out_fire_i  in  NumStreams  per-channel acc2stream valid&ready
- in_fire_i  in  NumStreams  per-channel stream2acc valid&ready
- csr_ro_o  out  4x32  [0] status, [1] cycles, [2] output beats, [3] input beats
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, CFG, RUN, DONE, ERR.
- IDLE/ERR: csr_set_ready_o=1. On accept, latch both words, clear the counters and the done/err bits, and go to CFG.
- CFG: cgra_csr_valid_o=1 and cgra_csr_o=latched command.
  - Ack: go to RUN, or to DONE if expected==0.
  - No ack within AckTimeout CFG cycles: go to ERR.
- RUN: each cycle, out_beats += popcount(out_fire_i) and in_beats += popcount(in_fire_i). Go to DONE when out_beats+popcount ≥ expected. The compare uses ≥ because several channels may fire in the crossing cycle, so overshoot is possible.
- DONE: done_o=1 for one cycle, set the sticky done bit, then go to IDLE.
- Counters saturate at 2^CntWidth−1. They are zero-extended to 32 bits on csr_ro_o.
- Cycle counter increments in every CFG and RUN cycle.
- Fire strobes outside RUN are ignored.
- All RO values hold after DONE/ERR until the next accept.
- Status word: bit0 busy (CFG|RUN), bit1 done (sticky), bit2 err (sticky), bits[5:3] state encoding, all other bits 0.

## Timing
- Reset values: state IDLE, all counters 0, status 0, cgra_csr_o 0, cgra_csr_valid_o 0, done_o 0.
- csr_set_ready_o = !rst_i && state∈{IDLE,ERR}. It is 0 while reset is asserted and 1 in the first cycle after release.
- Accept at cycle T: cgra_csr_valid_o=1 from T+1.
- Ack sampled high at T+k (k≥1; ack in the first valid cycle counts): valid drops at T+k+1 and state is RUN at T+k+1.
- Crossing beat at cycle R: counters updated and done_o=1 at R+1, IDLE at R+2, next accept possible at R+2.
- Timeout: valid has been high for AckTimeout cycles with no ack, so state is ERR and valid is 0 on the following cycle. Ack arriving in that last cycle wins.
- Reset mid-operation (any state): at the next edge, return to reset values. No done_o is issued for the aborted run.
- cgra_csr_o is stable throughout CFG. Valid never deasserts before ack or timeout.
- RO CSRs are registered and reflect counts one cycle after the fires.

## Structure
- Package snax_cgra_ctrl_pkg: state enum (3-bit), status bit index constants, RO CSR index constants.
- Sub-module snax_cgra_beat_counter: popcount of a NumStreams strobe vector plus a saturating CntWidth accumulator with clear and enable. It is instantiated twice, for output and input beats.
- The top holds the FSM, the timeout counter, the cycle counter and the launch registers.

## Test plan
- Launch cmd=0xA5A5_0001, expected=16, ack after 3 cycles, then out_fire_i=8'h03 for 8 cycles:
  - cgra_csr_valid_o high for exactly 3 cycles.
  - done_o pulses once, one cycle after the 8th fire cycle.
  - csr_ro_o[2]=16 and the status done bit is set.
- expected=10, with out_fire_i=8'hFF in the second RUN cycle after 4 beats: out_beats=12 and DONE is reached on that crossing.
- expected=0 with ack in the first CFG cycle: DONE follows CFG directly, done_o pulses, and out_beats=0.
- AckTimeout=4 with no ack: valid is high for 4 cycles, then state ERR, err=1, ready=1. A relaunch clears err and the counters.
- rst_i asserted mid-RUN with counts 5/7: next cycle all RO CSRs are 0, state IDLE, no done_o. Fires during IDLE leave the counters at 0.
- Back-to-back launch with csr_set_valid_i held high: second accept occurs 2 cycles after the first run's last fire; csr_set_ready_o stays 0 during CFG, RUN and DONE.
